// File: rtl/regfile_pkg.sv
// Shared helpers for the multi-port register file: default sizes and packed-port slicing.
// Also used by the hazard unit to decode the same packed address buses.
package regfile_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_NUM_RD   = 2;
  localparam int DEF_NUM_WR   = 2;

  // Address width for a file of num_regs entries; a 1-entry file still needs one bit.
  function automatic int addr_w(input int num_regs);
    return (num_regs < 2) ? 1 : $clog2(num_regs);
  endfunction

  // Low bit of port 'port' inside a packed bus of 'width'-bit fields.
  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one flop per register, set by producer issue, cleared by writeback.
// A set and a clear to the same register in one cycle leaves it busy (newer producer pending).
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_WR   = DEF_NUM_WR,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = addr_w(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_WR-1:0]    wr_en,
  input  logic [NUM_WR*AW-1:0] wr_addr,
  input  logic                 sb_set,
  input  logic [AW-1:0]        sb_addr,
  output logic [NUM_REGS-1:0]  busy_vec
);

  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;
  logic [NUM_REGS-1:0] busy_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    clr_vec = '0;
    set_vec = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j]) clr_vec[wr_addr[slice_lo(j, AW) +: AW]] = 1'b1;
    end
    if (sb_set) set_vec[sb_addr] = 1'b1;
    if (ZERO_REG) set_vec[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= set_vec | (busy_q & ~clr_vec);
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with write-priority muxing, optional write-to-read bypass
// and an attached busy-bit scoreboard for the hazard unit.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int NUM_WR   = DEF_NUM_WR,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = addr_w(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     sb_set,
  input  logic [AW-1:0]            sb_addr,
  output logic [NUM_REGS-1:0]      busy_vec
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] wr_hit;
  logic [DATA_W-1:0]   wr_val [NUM_REGS];

  // Per-register write decode. Ports are scanned in ascending order so the
  // highest-index enabled port is the last assignment and therefore wins.
  // NOTE: blocking assignments in combinational logic model this "last one wins"
  // priority directly; state registers below use non-blocking only.
  always_comb begin
    wr_hit = '0;
    for (int r = 0; r < NUM_REGS; r++) wr_val[r] = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j]) begin
        wr_hit[wr_addr[slice_lo(j, AW) +: AW]] = 1'b1;
        wr_val[wr_addr[slice_lo(j, AW) +: AW]] = wr_data[slice_lo(j, DATA_W) +: DATA_W];
      end
    end
    if (ZERO_REG) wr_hit[0] = 1'b0;
  end

  // NOTE: the storage array is reset because the architecture guarantees all
  // registers read 0 after reset; this makes it flops rather than a RAM macro.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (wr_hit[r]) regs_q[r] <= wr_val[r];
      end
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .sb_set   (sb_set),
    .sb_addr  (sb_addr),
    .busy_vec (busy_vec)
  );

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] data;

    assign addr = rd_addr[slice_lo(i, AW) +: AW];

    // Forwarding is gated by reset so a held reset reads 0 even with writes pending.
    always_comb begin
      data = regs_q[addr];
      if (BYPASS && reset_n) begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (wr_en[j] && (wr_addr[slice_lo(j, AW) +: AW] == addr)) begin
            data = wr_data[slice_lo(j, DATA_W) +: DATA_W];
          end
        end
      end
      if (ZERO_REG && (addr == '0)) data = '0;
    end

    assign rd_data[slice_lo(i, DATA_W) +: DATA_W] = data;
    assign rd_busy[i] = busy_vec[addr];
  end

  ap_zero_never_busy: assert property (
    @(posedge clk) disable iff (!reset_n) !(ZERO_REG && busy_vec[0]));

  ap_set_wins: assert property (
    @(posedge clk) disable iff (!reset_n)
    (sb_set && !(ZERO_REG && (sb_addr == '0))) |=> busy_vec[$past(sb_addr)]);

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb: directed scenarios followed by random traffic,
// compared against an array/bit-vector model of the architectural state.
module tb_regfile_mp_sb;

  localparam int DW  = 32;
  localparam int NR  = 32;
  localparam int NRD = 2;
  localparam int NWR = 2;
  localparam int AW  = 5;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic [NWR-1:0]    wr_en;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR*DW-1:0] wr_data;
  logic              sb_set;
  logic [AW-1:0]     sb_addr;
  logic [NR-1:0]     busy_vec;

  logic [AW-1:0] ra [NRD];
  logic [AW-1:0] wa [NWR];
  logic [DW-1:0] wd [NWR];

  logic [DW-1:0] mem [NR];
  bit            bsy [NR];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NRD; i++) rd_addr[i*AW +: AW] = ra[i];
    for (int j = 0; j < NWR; j++) begin
      wr_addr[j*AW +: AW] = wa[j];
      wr_data[j*DW +: DW] = wd[j];
    end
  end

  regfile_mp_sb #(
    .DATA_W (DW), .NUM_REGS (NR), .NUM_RD (NRD), .NUM_WR (NWR),
    .BYPASS (1'b1), .ZERO_REG (1'b1)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .sb_set   (sb_set),
    .sb_addr  (sb_addr),
    .busy_vec (busy_vec)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Architectural read: r0 is hard zero, otherwise the latest enabled write this
  // cycle (highest port) is forwarded, else the stored value.
  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    if (a == 0) return '0;
    v = mem[a];
    for (int j = 0; j < NWR; j++) if (wr_en[j] && wa[j] == a) v = wd[j];
    return v;
  endfunction

  function automatic logic [NR-1:0] exp_busy_vec();
    logic [NR-1:0] v;
    for (int r = 0; r < NR; r++) v[r] = bsy[r];
    return v;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      mem[r] = '0;
      bsy[r] = 1'b0;
    end
  endtask

  task automatic model_clock();
    for (int j = 0; j < NWR; j++) if (wr_en[j]) bsy[wa[j]] = 1'b0;
    for (int j = 0; j < NWR; j++) if (wr_en[j] && wa[j] != 0) mem[wa[j]] = wd[j];
    if (sb_set && sb_addr != 0) bsy[sb_addr] = 1'b1;
  endtask

  task automatic check_outputs(input string tag);
    for (int i = 0; i < NRD; i++) begin
      check($sformatf("%s_rd%0d", tag, i), 64'(rd_data[i*DW +: DW]), 64'(exp_read(ra[i])));
      check($sformatf("%s_busy%0d", tag, i), 64'(rd_busy[i]), 64'(bsy[ra[i]]));
    end
    check($sformatf("%s_vec", tag), 64'(busy_vec), 64'(exp_busy_vec()));
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic step(input string tag);
    #1 check_outputs(tag);
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en   = '0;
    sb_set  = 1'b0;
    sb_addr = '0;
    for (int j = 0; j < NWR; j++) begin
      wa[j] = '0;
      wd[j] = '0;
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 7));
    return AW'($urandom_range(0, NR - 1));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    idle();
    ra[0] = 5'd0;
    ra[1] = 5'd1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 check_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Write on port 0, then port 1 the next cycle, then read both back.
    wr_en = 2'b01; wa[0] = 5'd5; wd[0] = 32'hAABBCCDD; ra[0] = 5'd5; ra[1] = 5'd10;
    step("wr_p0");
    idle(); wr_en = 2'b10; wa[1] = 5'd10; wd[1] = 32'h11223344;
    step("wr_p1");
    idle();
    step("rd_5_10");

    // Same-address collision: port 1 wins, also through the bypass.
    wr_en = 2'b11; wa[0] = 5'd7; wd[0] = 32'h11111111; wa[1] = 5'd7; wd[1] = 32'h22222222;
    ra[0] = 5'd7; ra[1] = 5'd5;
    step("collide");
    idle();
    step("collide_after");

    // Register 0 ignores writes and scoreboard sets.
    wr_en = 2'b01; wa[0] = 5'd0; wd[0] = 32'hDEADBEEF; sb_set = 1'b1; sb_addr = 5'd0;
    ra[0] = 5'd0; ra[1] = 5'd0;
    step("zero_wr");
    idle();
    step("zero_after");

    // Scoreboard: set, clear by writeback, then set beating a same-cycle write.
    sb_set = 1'b1; sb_addr = 5'd15; ra[0] = 5'd15; ra[1] = 5'd7;
    step("sb_set");
    idle();
    step("sb_busy");
    wr_en = 2'b01; wa[0] = 5'd15; wd[0] = 32'hCAFEF00D;
    step("sb_wb");
    idle();
    step("sb_clear");
    wr_en = 2'b10; wa[1] = 5'd15; wd[1] = 32'h0BADF00D; sb_set = 1'b1; sb_addr = 5'd15;
    step("sb_both");
    idle();
    step("sb_setwins");

    // Asynchronous reset in the middle of a cycle.
    wr_en = 2'b01; wa[0] = 5'd5; wd[0] = 32'h12345678; sb_set = 1'b1; sb_addr = 5'd9;
    step("pre_rst");
    idle(); ra[0] = 5'd5; ra[1] = 5'd9;
    #1 check_outputs("loaded");
    #2 reset_n = 1'b0;
    model_reset();
    #1 check_outputs("async_rst");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    repeat (400) begin
      for (int i = 0; i < NRD; i++) ra[i] = rand_addr();
      for (int j = 0; j < NWR; j++) begin
        wr_en[j] = 1'($urandom_range(0, 1));
        wa[j]    = rand_addr();
        wd[j]    = $urandom;
      end
      sb_set  = ($urandom_range(0, 2) == 0);
      sb_addr = rand_addr();
      step("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
